// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, sync with signed position offsets,
// line/frame strobes and blank-gated RGB. Define VTG_OFFSET_LATCH_EN to latch offsets once per frame.
module video_timing_gen #(
    parameter int  H_TOTAL    = 396,
    parameter int  H_ACT_BEG  = 25,
    parameter int  H_ACT_END  = 265,
    parameter int  H_SYNC_BEG = 320,
    parameter int  H_SYNC_LEN = 31,
    parameter int  V_TOTAL    = 256,
    parameter int  V_ACT_END  = 224,
    parameter int  V_SYNC_BEG = 226,
    parameter int  V_SYNC_LEN = 5,
    parameter int  HPOS_BIAS  = 24,
    parameter int  RGB_W      = 12,
    parameter int  HOFF_W     = 5,
    parameter int  VOFF_W     = 4,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce_pix,
    input  logic signed [HOFF_W-1:0] hoffs,
    input  logic signed [VOFF_W-1:0] voffs,
    input  logic [RGB_W-1:0]         rgb_in,
    output logic [HW-1:0]            hpos,
    output logic [VW-1:0]            vpos,
    output logic                     hblank,
    output logic                     vblank,
    output logic                     hsync,
    output logic                     vsync,
    output logic [RGB_W-1:0]         rgb_out,
    output logic                     line_start,
    output logic                     frame_start
);

    localparam logic [HW-1:0] L_HPOS_BIAS = HW'(HPOS_BIAS);

    logic [HW-1:0]            r_hcnt;
    logic [VW-1:0]            r_vcnt;
    logic                     r_hblank;
    logic                     r_vblank;
    logic                     r_hsync;
    logic                     r_vsync;
    logic [RGB_W-1:0]         r_rgb_out;
    logic                     r_line_start;
    logic                     r_frame_start;

    logic                     w_h_last;
    logic                     w_v_last;
    logic                     w_frame_wrap;
    logic                     w_hblank_nxt;
    logic                     w_vblank_nxt;
    logic                     w_hsync_nxt;
    logic                     w_vsync_nxt;
    logic signed [HOFF_W-1:0] w_hoffs_eff;
    logic signed [VOFF_W-1:0] w_voffs_eff;
    int                       w_hsb;
    int                       w_vsb;

    // Offset magnitude is assumed smaller than the total, so one fold brings the sum into range.
    function automatic int sync_start(input int nominal, input int offset, input int total);
        int s;
        s = nominal + offset;
        if (s < 0) begin
            s = s + total;
        end else if (s >= total) begin
            s = s - total;
        end
        return s;
    endfunction

    // Distance from the sync start, taken modulo the total so the window can straddle the wrap.
    function automatic logic sync_hit(input int cnt, input int start, input int total, input int len);
        int d;
        d = cnt - start;
        if (d < 0) begin
            d = d + total;
        end
        return d < len;
    endfunction

    assign w_h_last     = (int'(r_hcnt) == H_TOTAL - 1);
    assign w_v_last     = (int'(r_vcnt) == V_TOTAL - 1);
    assign w_frame_wrap = ce_pix & w_h_last & w_v_last;

`ifdef VTG_OFFSET_LATCH_EN
    logic signed [HOFF_W-1:0] r_hoffs_eff;
    logic signed [VOFF_W-1:0] r_voffs_eff;

    // Captured on the last pixel of the frame so the new offsets start exactly at line 0.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hoffs_eff <= '0;
            r_voffs_eff <= '0;
        end else if (w_frame_wrap) begin
            r_hoffs_eff <= hoffs;
            r_voffs_eff <= voffs;
        end
    end

    assign w_hoffs_eff = r_hoffs_eff;
    assign w_voffs_eff = r_voffs_eff;
`else
    assign w_hoffs_eff = hoffs;
    assign w_voffs_eff = voffs;
`endif

    assign w_hsb = sync_start(H_SYNC_BEG, int'(w_hoffs_eff), H_TOTAL);
    assign w_vsb = sync_start(V_SYNC_BEG, int'(w_voffs_eff), V_TOTAL);

    assign w_hblank_nxt = (int'(r_hcnt) < H_ACT_BEG) || (int'(r_hcnt) >= H_ACT_END);
    assign w_vblank_nxt = (int'(r_vcnt) >= V_ACT_END);
    assign w_hsync_nxt  = sync_hit(int'(r_hcnt), w_hsb, H_TOTAL, H_SYNC_LEN);
    assign w_vsync_nxt  = sync_hit(int'(r_vcnt), w_vsb, V_TOTAL, V_SYNC_LEN);

    // Outputs are evaluated from the pre-increment counts, so they trail the counters by one ce.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_rgb_out     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (ce_pix) begin
                r_hblank      <= w_hblank_nxt;
                r_vblank      <= w_vblank_nxt;
                r_hsync       <= w_hsync_nxt;
                r_vsync       <= w_vsync_nxt;
                r_rgb_out     <= (w_hblank_nxt | w_vblank_nxt) ? '0 : rgb_in;
                r_line_start  <= w_h_last;
                r_frame_start <= w_h_last & w_v_last;
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
                end else begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end
        end
    end

    assign hpos        = r_hcnt - L_HPOS_BIAS;
    assign vpos        = r_vcnt;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb_out;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three geometries (default, wrapped hsync, small frame) checked
// every clock against a reference model through an expected-value queue.
module tb_video_timing_gen;

    localparam int W = 35;

    typedef struct {
        int ht, hab, hae, hsb, hsl, vt, vae, vsb, vsl, bias, hw;
    } geom_t;

    // clock / reset block
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic                reset  = 1'b1;
    logic                ce_pix = 1'b0;
    logic [11:0]         rgb_in = '0;
    logic signed [4:0]   hoffs_v [3];
    logic signed [3:0]   voffs_v [3];

    logic [8:0]  d0_hpos;  logic [7:0] d0_vpos;
    logic [8:0]  d1_hpos;  logic [1:0] d1_vpos;
    logic [4:0]  d2_hpos;  logic [3:0] d2_vpos;
    logic        d0_hblank, d0_vblank, d0_hsync, d0_vsync, d0_ls, d0_fs;
    logic        d1_hblank, d1_vblank, d1_hsync, d1_vsync, d1_ls, d1_fs;
    logic        d2_hblank, d2_vblank, d2_hsync, d2_vsync, d2_ls, d2_fs;
    logic [11:0] d0_rgb, d1_rgb, d2_rgb;
    logic [W-1:0] w_obs [3];

    video_timing_gen u_dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_v[0]), .voffs(voffs_v[0]),
        .rgb_in(rgb_in), .hpos(d0_hpos), .vpos(d0_vpos), .hblank(d0_hblank), .vblank(d0_vblank),
        .hsync(d0_hsync), .vsync(d0_vsync), .rgb_out(d0_rgb), .line_start(d0_ls), .frame_start(d0_fs)
    );

    video_timing_gen #(
        .H_SYNC_BEG(390), .V_TOTAL(4), .V_ACT_END(3), .V_SYNC_BEG(1), .V_SYNC_LEN(1)
    ) u_wrap (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_v[1]), .voffs(voffs_v[1]),
        .rgb_in(rgb_in), .hpos(d1_hpos), .vpos(d1_vpos), .hblank(d1_hblank), .vblank(d1_vblank),
        .hsync(d1_hsync), .vsync(d1_vsync), .rgb_out(d1_rgb), .line_start(d1_ls), .frame_start(d1_fs)
    );

    video_timing_gen #(
        .H_TOTAL(20), .H_ACT_BEG(2), .H_ACT_END(15), .H_SYNC_BEG(16), .H_SYNC_LEN(3),
        .V_TOTAL(12), .V_ACT_END(9), .V_SYNC_BEG(8), .V_SYNC_LEN(2), .HPOS_BIAS(1)
    ) u_small (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_v[2]), .voffs(voffs_v[2]),
        .rgb_in(rgb_in), .hpos(d2_hpos), .vpos(d2_vpos), .hblank(d2_hblank), .vblank(d2_vblank),
        .hsync(d2_hsync), .vsync(d2_vsync), .rgb_out(d2_rgb), .line_start(d2_ls), .frame_start(d2_fs)
    );

    assign w_obs[0] = {d0_hblank, d0_vblank, d0_hsync, d0_vsync, d0_ls, d0_fs, d0_rgb, d0_hpos, d0_vpos};
    assign w_obs[1] = {d1_hblank, d1_vblank, d1_hsync, d1_vsync, d1_ls, d1_fs, d1_rgb, d1_hpos,
                       6'b0, d1_vpos};
    assign w_obs[2] = {d2_hblank, d2_vblank, d2_hsync, d2_vsync, d2_ls, d2_fs, d2_rgb, 4'b0, d2_hpos,
                       4'b0, d2_vpos};

    // scoreboard and model state
    logic [W-1:0] exp_q [$];
    geom_t        g [3];
    int           m_h [3];
    int           m_v [3];
    int           m_hoff [3];
    int           m_voff [3];
    logic [17:0]  m_out [3];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_steps  = 0;

    function automatic bit in_win(input int x, input int beg, input int off, input int len, input int tot);
        int s;
        s = ((beg + off) % tot + tot) % tot;
        for (int k = 0; k < len; k++) begin
            if ((s + k) % tot == x) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit ce, input logic [11:0] rgb);
        geom_t q;
        int ho, vo;
        bit hb, vb, hs, vs, ls, fs;
        logic [11:0] px;
        q = g[i];
        if (rst) begin
            m_h[i] = 0; m_v[i] = 0; m_hoff[i] = 0; m_voff[i] = 0;
            m_out[i] = {1'b1, 1'b1, 4'b0000, 12'h000};
        end else if (ce) begin
`ifdef VTG_OFFSET_LATCH_EN
            ho = m_hoff[i]; vo = m_voff[i];
`else
            ho = int'(hoffs_v[i]); vo = int'(voffs_v[i]);
`endif
            hb = (m_h[i] < q.hab) || (m_h[i] >= q.hae);
            vb = (m_v[i] >= q.vae);
            hs = in_win(m_h[i], q.hsb, ho, q.hsl, q.ht);
            vs = in_win(m_v[i], q.vsb, vo, q.vsl, q.vt);
            px = (hb || vb) ? 12'h000 : rgb;
            ls = (m_h[i] == q.ht - 1);
            fs = ls && (m_v[i] == q.vt - 1);
            if (ls) begin
                m_h[i] = 0;
                m_v[i] = (m_v[i] == q.vt - 1) ? 0 : m_v[i] + 1;
            end else begin
                m_h[i] = m_h[i] + 1;
            end
            if (fs) begin
                m_hoff[i] = int'(hoffs_v[i]);
                m_voff[i] = int'(voffs_v[i]);
            end
            m_out[i] = {hb, vb, hs, vs, ls, fs, px};
        end else begin
            m_out[i] = {m_out[i][17:14], 2'b00, m_out[i][11:0]};
        end
        exp_q.push_back({m_out[i], 9'((m_h[i] - q.bias) & ((1 << q.hw) - 1)), 8'(m_v[i])});
    endtask

    // driver: one clk_sys cycle, expectations queued at drive time and compared after the edge
    task automatic step(input bit rst, input bit ce);
        logic [W-1:0] e;
        @(negedge clk_sys);
        reset  = rst;
        ce_pix = ce;
        rgb_in = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 3; i++) model_step(i, rst, ce, rgb_in);
        @(posedge clk_sys);
        #1;
        n_steps++;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            check_val($sformatf("dut%0d_step%0d", i, n_steps), w_obs[i], e);
        end
    endtask

    initial begin
        int first, cnt, wcnt, ls_cnt, fs_cnt, exp_start;
        g[0] = '{ht:396, hab:25, hae:265, hsb:320, hsl:31, vt:256, vae:224, vsb:226, vsl:5, bias:24, hw:9};
        g[1] = '{ht:396, hab:25, hae:265, hsb:390, hsl:31, vt:4,   vae:3,   vsb:1,   vsl:1, bias:24, hw:9};
        g[2] = '{ht:20,  hab:2,  hae:15,  hsb:16,  hsl:3,  vt:12,  vae:9,   vsb:8,   vsl:2, bias:1,  hw:5};
        for (int i = 0; i < 3; i++) begin
            hoffs_v[i] = '0;
            voffs_v[i] = '0;
        end
        hoffs_v[1] = 5'sd3;

        // reset asserted together with ce: reset wins
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // two full default lines, ce every clk
        first = -1; cnt = 0; wcnt = 0; ls_cnt = 0;
        for (int k = 1; k <= 792; k++) begin
            step(1'b0, 1'b1);
            if (k == 25 || k == 26 || k == 265 || k == 266)
                check_val($sformatf("hblank_after_ce%0d", k), W'(d0_hblank), W'(k == 25 || k == 266));
            if (k <= 396) begin
                if (d0_hsync) begin
                    if (first < 0) first = k - 1;
                    cnt++;
                end
                if (d1_hsync) wcnt++;
            end
            ls_cnt += int'(d0_ls);
        end
        check_val("hsync_start_hoffs0", W'(first), W'(320));
        check_val("hsync_width_hoffs0", W'(cnt), W'(31));
        check_val("wrap_hsync_width", W'(wcnt), W'(31));
        check_val("line_start_count", W'(ls_cnt), W'(2));

        // negative hsync offset on the default geometry
        hoffs_v[0] = -5'sd16;
        first = -1; cnt = 0;
        for (int k = 1; k <= 396; k++) begin
            step(1'b0, 1'b1);
            if (d0_hsync) begin
                if (first < 0) first = k - 1;
                cnt++;
            end
        end
`ifdef VTG_OFFSET_LATCH_EN
        exp_start = 320;
`else
        exp_start = 304;
`endif
        check_val("hsync_start_hoffs_m16", W'(first), W'(exp_start));
        check_val("hsync_width_hoffs_m16", W'(cnt), W'(31));

        // let the wrapped-hsync geometry run across several frames
        for (int k = 0; k < 2000; k++) step(1'b0, 1'b1);

        // vsync offset change mid-frame on the small geometry
        step(1'b1, 1'b1);
        for (int k = 1; k <= 100; k++) step(1'b0, 1'b1);
        voffs_v[2] = 4'sd3;
        first = -1; fs_cnt = 0;
        for (int k = 101; k <= 820; k++) begin
            step(1'b0, 1'b1);
            if (k <= 240 && d2_vsync && first < 0) first = (k - 1) / 20;
            fs_cnt += int'(d2_fs);
        end
`ifdef VTG_OFFSET_LATCH_EN
        exp_start = 8;
`else
        exp_start = 11;
`endif
        check_val("small_first_vsync_line", W'(first), W'(exp_start));
        check_val("small_frame_start_count", W'(fs_cnt), W'(3));

        // sparse ce: outputs hold between enables, strobes last one clk
        for (int k = 0; k < 400; k++) step(1'b0, (k % 8) == 0);

        // random ce with random offsets on the default and small geometries
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                hoffs_v[0] = 5'($urandom_range(0, 31));
                voffs_v[0] = 4'($urandom_range(0, 15));
                hoffs_v[2] = 5'($urandom_range(0, 31));
                voffs_v[2] = 4'($urandom_range(0, 15));
            end
            step(1'b0, $urandom_range(0, 3) == 0);
        end

        // reset mid-frame (small geometry at hcnt=12, vcnt=7) coincident with ce
        step(1'b1, 1'b1);
        for (int k = 0; k < 152; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_val("reset_hpos_small", W'(d2_hpos), W'(5'd31));
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
        check_val("restart_vpos_small", W'(d2_vpos), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for arcade cores, clocked on the system clock and advanced by a pixel clock-enable. It produces the pixel and line counters, blanking, sync, frame and line strobes, and blank-gated RGB. Per-frame signed H/V sync offsets provide analog-video position adjustment. It sits between the game core's video output and the video scaler/output stage, and supersedes fixed-geometry per-core generators.

## Interface
Parameters:
- H_TOTAL, 396, pixels per line
- H_ACT_BEG, 25, first active hcnt
- H_ACT_END, 265, first hcnt blanked after active region
- H_SYNC_BEG, 320, nominal hsync start hcnt
- H_SYNC_LEN, 31, hsync length in pixels
- V_TOTAL, 256, lines per frame
- V_ACT_END, 224, first blanked line (active lines are 0..V_ACT_END-1)
- V_SYNC_BEG, 226, nominal vsync start line
- V_SYNC_LEN, 5, vsync length in lines
- HPOS_BIAS, 24, subtracted from hcnt to form hpos
- RGB_W, 12, pixel data width
- HOFF_W / VOFF_W, 5 / 4, offset widths

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel enable; all state advances only when high
- hoffs  in  HOFF_W  signed hsync offset
- voffs  in  VOFF_W  signed vsync offset
- rgb_in  in  RGB_W  pixel from core
- hpos  out  HW=$clog2(H_TOTAL)  hcnt-HPOS_BIAS, modulo 2^HW, combinational from counter
- vpos  out  VW=$clog2(V_TOTAL)  vcnt
- hblank, vblank, hsync, vsync  out  1  registered, active-high
- rgb_out  out  RGB_W  registered; 0 while blanked
- line_start, frame_start  out  1  single-clk_sys strobes

## Operation
- hcnt runs 0..H_TOTAL-1. At wrap, hcnt←0 and vcnt increments; vcnt wraps V_TOTAL-1→0. All widths are sized to hold the totals; there is no power-of-two assumption.
- On each ce_pix, the outputs are evaluated from the pre-increment counts:
  - hblank = hcnt<H_ACT_BEG | hcnt>=H_ACT_END
  - vblank = vcnt>=V_ACT_END
  - rgb_out = (new hblank|new vblank) ? 0 : rgb_in
- Effective sync start:
  - HSB = (H_SYNC_BEG + sext(hoffs_eff)) mod H_TOTAL, normalised into 0..H_TOTAL-1 by ±H_TOTAL.
  - VSB is formed the same way against V_TOTAL.
- hsync is high when (hcnt-HSB) mod H_TOTAL < H_SYNC_LEN, so the sync window wraps across line end. vsync uses the same rule on vcnt.
- line_start pulses on the ce where hcnt wraps. frame_start pulses on the ce where hcnt and vcnt both wrap.
- Reset values:
  - hcnt=0, vcnt=0
  - hblank=1, vblank=1, hsync=0, vsync=0
  - rgb_out=0, strobes=0
  - offset latches=0
- Reset asserted mid-frame takes priority over ce_pix on the same edge.

## Timing
- Single clock. With ce_pix low, every register holds and the strobes are 0.
- Registered outputs lag the counter by one ce: the output after ce #k reflects hcnt=k-1 following reset.
- rgb_out latency is one ce from rgb_in.
- Strobe width is exactly one clk_sys cycle, independent of ce spacing.
- The offset latch updates on the frame_start edge and takes effect from line 0 of the new frame.

## Configuration
- VTG_OFFSET_LATCH_EN defined: hoffs_eff and voffs_eff are registers captured at frame_start (and cleared by reset). Offset changes never tear a frame.
- Not defined: hoffs_eff=hoffs and voffs_eff=voffs, used live with no latch registers.

## Test plan
- Defaults, reset then ce every clk:
  - hblank falls after ce #26 and rises after ce #266.
  - line_start pulses once every 396 clks.
  - vblank rises on line 224 and falls on line 0.
- hoffs=0: hsync high for hcnt 320..350. hoffs=-16: hsync high for 304..334. Width is 31 pixels in both cases.
- Override H_SYNC_BEG=390, hoffs=+3: hsync high for hcnt 393..395 then 0..27. Check continuity across the wrap.
- LATCH_EN: set voffs 0→3 at line 100.
  - Current frame: vsync on lines 226..230.
  - Next frame: vsync on lines 229..233.
  - Without LATCH_EN, 229..233 already applies in the current frame.
- ce_pix every 8th clk: outputs hold between enables; frame_start period is 811008 clks with 1-clk width.
- Reset asserted at hcnt=200, vcnt=150 coincident with ce:
  - Next cycle all outputs hold their reset values.
  - Counting restarts from 0,0 on the first ce after release.
